muldiv_seq_ctrl: RTL
====================

MULDIV_SEQ_CTRL -- requirements
Module: muldiv_seq_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 2: number of iteration steps for MUL/MULH/MULHSU/MULHU, legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 32: number of iteration steps for DIV/DIVU/REM/REMU, legal range 1..63.
REQ-003 clk  in  1  single clock, all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 EXE_muldiv_valid  in  1  EXE stage holds an M-extension instruction.
REQ-006 EXE_muldiv_op  in  3  funct3 of that instruction; bit 2 set means divide class.
REQ-007 EXE_write_addr  in  5  destination register of that instruction.
REQ-008 EXE_flush  in  1  branch, interrupt or return flush of the EXE stage.
REQ-009 divisor_zero  in  1  rs2 operand equals zero, valid while EXE_muldiv_valid is high.
REQ-010 muldiv_stall  out  1  freeze PC, IF/ID and ID/EXE; combinational from state and inputs.
REQ-011 dp_load  out  1  datapath captures operands and op.
REQ-012 dp_step  out  1  datapath performs one iteration.
REQ-013 dp_op  out  3  registered op driven to the datapath.
REQ-014 result_valid  out  1  one-cycle pulse; datapath result is final.
REQ-015 result_wb_addr  out  5  registered destination register for write-back.

Function
REQ-016 FSM states are IDLE, BUSY and DONE.
REQ-017 IDLE with EXE_muldiv_valid=1 and EXE_flush=0 (cycle T): dp_load=1 and muldiv_stall=1 in the same cycle; op and address are latched; counter is loaded with N-1, where N=DIV_CYCLES if op[2] else MUL_CYCLES; next state is BUSY.
REQ-018 BUSY: dp_step=1 and muldiv_stall=1 every cycle; the counter decrements; when the counter equals 0 the next state is DONE, giving exactly N steps in cycles T+1..T+N.
REQ-019 DONE (cycle T+N+1): result_valid=1, muldiv_stall=0, and EXE_muldiv_valid is ignored; next state is IDLE.
REQ-020 The instruction that completes is the one that advances out of EXE in the DONE cycle, so there is no re-trigger; a new M instruction can start at T+N+2 at the earliest.
REQ-021 EXE_flush=1 in any state returns the FSM to IDLE on the next edge; muldiv_stall=0, dp_load=0, dp_step=0 and result_valid=0 in that cycle; flush overrides completion.
REQ-022 EXE_muldiv_valid=1 while in IDLE and EXE_flush=1 in the same cycle does not start an operation.
REQ-023 The counter is 6 bits wide and never wraps: decrement occurs only in BUSY while it is nonzero.
REQ-024 dp_op and result_wb_addr hold their latched values from load until the next load.

Reset
REQ-025 rst=1 sets: state IDLE, counter 0, dp_op 0, result_wb_addr 0; every output is 0 in the cycle after.
REQ-026 Reset asserted during BUSY aborts the operation: no result_valid, and muldiv_stall is 0 from the next cycle.

Configuration
REQ-027 Macro MULDIV_DIVZERO_BYPASS_EN defined: a divide-class start with divisor_zero=1 goes IDLE->DONE directly; dp_load=1 and zero dp_step pulses occur, result_valid rises at T+1, and the datapath returns the RISC-V divide-by-zero result.
REQ-028 Macro undefined: a divide by zero takes the full DIV_CYCLES path like any other divide.

Structure
REQ-029 Package muldiv_pkg holds: the state enum; funct3 localparams (MUL..REMU); the counter width; and the default MUL_CYCLES and DIV_CYCLES.
REQ-030 Sub-module muldiv_step_counter (load, decrement, zero flag) is instantiated once; FSM and output decode live in muldiv_seq_ctrl.

Verification
REQ-031 MUL (op=000, rd=5) at T, defaults -> stall=1 at T..T+2, dp_step at T+1..T+2, result_valid=1 with wb_addr=5 at T+3 only.
REQ-032 DIVU (op=101, rd=10) at T -> 32 dp_step pulses, stall=1 at T..T+32, result_valid at T+33.
REQ-033 DIV started at T with EXE_flush=1 at T+10 -> stall=0 at T+10, state IDLE at T+11, no result_valid ever.
REQ-034 DIV with divisor_zero=1: with MULDIV_DIVZERO_BYPASS_EN -> result_valid at T+1 and no dp_step; without it -> result_valid at T+33.
REQ-035 rst=1 at T+5 of a DIV -> all outputs 0 at T+6; a new MUL at T+7 completes at T+10.
REQ-036 Back-to-back MULs with valid held high -> result_valid at T+3, second load at T+4, second result_valid at T+7; no double completion.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the M-extension sequencer.
package muldiv_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
    localparam int CNT_W = 6;
    localparam int MUL_CYCLES_DEF = 2;
    localparam int DIV_CYCLES_DEF = 32;
endpackage

// File: rtl/muldiv_step_counter.sv
// muldiv_step_counter: loadable down-counter that saturates at zero.
module muldiv_step_counter
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: IDLE/BUSY/DONE sequencer for the iterative mul/div datapath.
// MULDIV_DIVZERO_BYPASS_EN: divide by zero skips straight from load to DONE.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EXE_muldiv_valid,
    input  logic [2:0] EXE_muldiv_op,
    input  logic [4:0] EXE_write_addr,
    input  logic       EXE_flush,
    input  logic       divisor_zero,
    output logic       muldiv_stall,
    output logic       dp_load,
    output logic       dp_step,
    output logic [2:0] dp_op,
    output logic       result_valid,
    output logic [4:0] result_wb_addr
);
`ifdef MULDIV_DIVZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif
    state_t state;
    logic start, bypass, cnt_zero;
    logic [CNT_W-1:0] cnt_init;

    assign start    = state == IDLE && EXE_muldiv_valid && !EXE_flush;
    assign bypass   = BYPASS_EN && EXE_muldiv_op[2] && divisor_zero;
    assign cnt_init = EXE_muldiv_op[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    // Flush masks every strobe in the cycle it is seen.
    assign dp_load      = start;
    assign dp_step      = !EXE_flush && state == BUSY;
    assign result_valid = !EXE_flush && state == DONE;
    assign muldiv_stall = start || dp_step;

    muldiv_step_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (cnt_init),
        .dec      (state == BUSY),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dp_op          <= '0;
            result_wb_addr <= '0;
        end else begin
            if (start) begin
                dp_op          <= EXE_muldiv_op;
                result_wb_addr <= EXE_write_addr;
            end
            state <= EXE_flush     ? IDLE :
                     start         ? (bypass ? DONE : BUSY) :
                     state == BUSY ? (cnt_zero ? DONE : BUSY) : IDLE;
        end
    end
endmodule
